// File: rtl/count_event_monitor.sv
// count_event_monitor: watches a 4-bit up/down/load counter, keeps a signed
// wrap epoch, classifies each count transition (OVF/UNF/MATCH/LOAD) and queues
// the events in a small first-word-fall-through FIFO with valid/ready output.
module count_event_monitor #(
  parameter int CNT_W      = 4,
  parameter int EPOCH_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   count_in,
  input  logic               load_in,
  input  logic               cnt_rst_in,
  input  logic               match_en,
  input  logic [CNT_W-1:0]   match_val,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_type,
  output logic [CNT_W-1:0]   evt_count,
  output logic [EPOCH_W-1:0] evt_epoch,
  output logic [EPOCH_W-1:0] epoch,
  output logic               drop_err,
  input  logic               clr_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 2 + CNT_W + EPOCH_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0]      DEPTH_V = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] T_OVF   = 2'b00;
  localparam logic [1:0] T_UNF   = 2'b01;
  localparam logic [1:0] T_MATCH = 2'b10;
  localparam logic [1:0] T_LOAD  = 2'b11;

  logic [CNT_W-1:0]   prev;
  logic               prev_valid, ld_d, rs_d;

  logic               det;
  logic [1:0]         det_type;
  logic [EPOCH_W-1:0] nxt_epoch;

  logic [FIFO_DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        used;
  logic [EW-1:0]      last, head;
  logic               full, pop, push, drop;

  // Capture previous count and delay controls to line up with the count change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      ld_d       <= 1'b0;
      rs_d       <= 1'b0;
    end else begin
      prev       <= count_in;
      prev_valid <= 1'b1;
      ld_d       <= load_in;
      rs_d       <= cnt_rst_in;
    end
  end

  // Prioritised classification; an unchanged count never produces an event
  always_comb begin
    det       = 1'b0;
    det_type  = T_OVF;
    nxt_epoch = epoch;
    if (prev_valid && (count_in != prev)) begin
      if (rs_d) begin
        det       = 1'b1;
        det_type  = T_LOAD;
        nxt_epoch = '0;
      end else if (ld_d) begin
        det      = 1'b1;
        det_type = T_LOAD;
      end else if ((prev == CNT_MAX) && (count_in == '0)) begin
        det       = 1'b1;
        det_type  = T_OVF;
        nxt_epoch = epoch + EPOCH_W'(1);
      end else if ((prev == '0) && (count_in == CNT_MAX)) begin
        det       = 1'b1;
        det_type  = T_UNF;
        nxt_epoch = epoch - EPOCH_W'(1);
      end else if (match_en && (count_in == match_val)) begin
        det      = 1'b1;
        det_type = T_MATCH;
      end
    end
  end

  // A slot freed by a same-cycle pop can take the new event
  always_comb begin
    full = (used == DEPTH_V);
    pop  = evt_valid && evt_ready;
    push = det && (!full || pop);
    drop = det && full && !pop;
    head = mem[rd_ptr];
  end

  // Epoch follows every classified event, including dropped ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) epoch <= '0;
    else      epoch <= nxt_epoch;
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         drop_err <= 1'b0;
    else if (drop)    drop_err <= 1'b1;
    else if (clr_err) drop_err <= 1'b0;
  end

  // FIFO storage, pointers and occupancy; last holds the most recently popped entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      last   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {det_type, count_in, nxt_epoch};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= head;
      end
      case ({push, pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  // Fall-through outputs: head when non-empty, else the last popped entry
  always_comb begin
    evt_valid = (used != '0);
    {evt_type, evt_count, evt_epoch} = evt_valid ? head : last;
  end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: reset, OVF/UNF, load/reset
// classification, match edge detection, FIFO overflow/drain and async reset.
module tb_count_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       load_in, cnt_rst_in, match_en, evt_ready, clr_err;
  logic [3:0] match_val;
  logic       evt_valid, drop_err;
  logic [1:0] evt_type;
  logic [3:0] evt_count;
  logic [7:0] evt_epoch, epoch;

  int vectors = 0;
  int errs    = 0;

  count_event_monitor #(.CNT_W(4), .EPOCH_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .load_in(load_in),
    .cnt_rst_in(cnt_rst_in), .match_en(match_en), .match_val(match_val),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_count(evt_count), .evt_epoch(evt_epoch), .epoch(epoch),
    .drop_err(drop_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] c);
    count_in = c;
    tick();
  endtask

  task automatic ovf();
    step(4'd7);
    step(4'd15);
    step(4'd0);
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; count_in = 4'd0; load_in = 1'b0; cnt_rst_in = 1'b0;
    match_en = 1'b0; match_val = 4'd0; evt_ready = 1'b1; clr_err = 1'b0;
    #12;
    chk("rst_valid", evt_valid, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_evt", {evt_type, evt_count, evt_epoch}, 0);
    rst = 1'b1;

    // 1: 14,15,0 -> one OVF
    step(4'd14); chk("t1_cap", evt_valid, 0);
    step(4'd15); chk("t1_nowrap", evt_valid, 0);
    step(4'd0);
    chk("t1_valid", evt_valid, 1);
    chk("t1_type", evt_type, 0);
    chk("t1_count", evt_count, 0);
    chk("t1_eepoch", evt_epoch, 1);
    chk("t1_epoch", epoch, 1);
    step(4'd0);
    chk("t1_popped", evt_valid, 0);
    chk("t1_hold", evt_epoch, 1);

    // 2: after reset, 1,0,15 -> one UNF, epoch 255
    rst = 1'b0; #1;
    chk("t2_async_epoch", epoch, 0);
    @(negedge clk); rst = 1'b1;
    step(4'd1); step(4'd0); chk("t2_none", evt_valid, 0);
    step(4'd15);
    chk("t2_valid", evt_valid, 1);
    chk("t2_type", evt_type, 1);
    chk("t2_count", evt_count, 15);
    chk("t2_eepoch", evt_epoch, 255);
    chk("t2_epoch", epoch, 255);
    step(4'd15);

    // 3: load 0 while count=15, then counter sync reset
    load_in = 1'b1; step(4'd15); load_in = 1'b0;
    chk("t3_ldcyc", evt_valid, 0);
    step(4'd0);
    chk("t3_ld_valid", evt_valid, 1);
    chk("t3_ld_type", evt_type, 3);
    chk("t3_ld_count", evt_count, 0);
    chk("t3_ld_eepoch", evt_epoch, 255);
    chk("t3_ld_epoch", epoch, 255);
    step(4'd3);
    cnt_rst_in = 1'b1; step(4'd3); cnt_rst_in = 1'b0;
    chk("t3_rscyc", evt_valid, 0);
    step(4'd0);
    chk("t3_rs_type", {evt_valid, evt_type}, 3'b111);
    chk("t3_rs_eepoch", evt_epoch, 0);
    chk("t3_rs_epoch", epoch, 0);

    // 4: match on 5 fires once; OVF beats MATCH on 0
    match_en = 1'b1; match_val = 4'd5;
    step(4'd4); chk("t4_pre", evt_valid, 0);
    step(4'd5);
    chk("t4_m_valid", evt_valid, 1);
    chk("t4_m_type", evt_type, 2);
    chk("t4_m_count", evt_count, 5);
    step(4'd5); chk("t4_held", evt_valid, 0);
    step(4'd6); chk("t4_six", evt_valid, 0);
    match_val = 4'd0;
    step(4'd15); chk("t4_15", evt_valid, 0);
    step(4'd0);
    chk("t4_ovf", {evt_valid, evt_type}, 3'b100);
    chk("t4_ovf_epoch", evt_epoch, 1);
    step(4'd0); chk("t4_nodefer", evt_valid, 0);
    match_en = 1'b0;

    // 5: 5 overflows into a 4-deep FIFO with no consumer, then drain
    rst_pulse();
    evt_ready = 1'b0;
    step(4'd7);
    for (int i = 0; i < 5; i++) ovf();
    chk("t5_valid", evt_valid, 1);
    chk("t5_drop", drop_err, 1);
    chk("t5_epoch", epoch, 5);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t5_drain%0d", i), {evt_valid, evt_type, evt_epoch}, {1'b1, 2'b00, 8'(i)});
      step(4'd0);
    end
    chk("t5_empty", evt_valid, 0);
    chk("t5_sticky", drop_err, 1);
    clr_err = 1'b1; step(4'd0); clr_err = 1'b0;
    chk("t5_clr", drop_err, 0);

    // 6: async reset mid-drain, then first sample captures only
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) ovf();
    chk("t6_drop", drop_err, 1);
    evt_ready = 1'b1;
    step(4'd0);
    chk("t6_mid", evt_valid, 1);
    rst = 1'b0; #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_epoch", epoch, 0);
    chk("t6_rst_drop", drop_err, 0);
    @(negedge clk); rst = 1'b1;
    step(4'd15); chk("t6_first", evt_valid, 0);
    step(4'd0);
    chk("t6_ovf", {evt_valid, evt_type}, 3'b100);
    chk("t6_ovf_epoch", evt_epoch, 1);
    chk("t6_epoch", epoch, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
